fractal_job_scheduler: RTL and testbench
========================================

# fractal_job_scheduler

Sequences fractal pixel computation for one frame. It walks the raster, dispatches pixel coordinates round-robin to NUM_ENG iteration engines, and collects their results strictly in raster order. Results leave as an AXI4-Stream video stream with tuser marking start of frame and tlast marking end of line. It sits between the engine array and the stream output port of the pixel generator.

## Interface
- X_SIZE, 640, pixels per line (≥2, ≤2047)
- Y_SIZE, 480, lines per frame (≥1, ≤2047)
- NUM_ENG, 4, number of engines (power of two, 1..16); IW = max(1, clog2(NUM_ENG))
- out_stream_aclk  in  1  sole clock
- periph_reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a frame (ignored unless IDLE)
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse after the last pixel handshake
- eng_idle  in  NUM_ENG  engine i idle, result consumed, can accept start
- eng_start  out  NUM_ENG  one-hot, one-cycle start pulse
- eng_x  out  11  x coordinate, valid with eng_start
- eng_y  out  11  y coordinate, valid with eng_start
- eng_done  in  NUM_ENG  engine i holds a result; stays high until acked
- eng_result  in  8*NUM_ENG  iteration count; engine i at bits [8i+7:8i]
- eng_ack  out  NUM_ENG  one-hot, one-cycle; result consumed
- out_stream_tdata  out  32  {8'h00, r, g, b}; r = g = b = result
- out_stream_tkeep  out  4  constant 4'hF
- out_stream_tvalid  out  1  pixel available
- out_stream_tready  in  1  sink ready
- out_stream_tuser  out  1  start of frame, on pixel (0,0)
- out_stream_tlast  out  1  end of line, on x = X_SIZE-1

## Operation
- States are IDLE, RUN and DRAIN. All outputs reset to 0 except tkeep, which is 4'hF. Reset also zeroes the state, all pointers and all counters.
- IDLE → RUN on start. This clears the issue coordinates (ix, iy), the collect coordinates (ox, oy), issue_ptr and col_ptr.
- Issue rule, in RUN only: when eng_idle[issue_ptr] = 1, the block does the following in that cycle:
  - registers eng_start = 1 << issue_ptr, eng_x = ix and eng_y = iy;
  - increments issue_ptr modulo NUM_ENG;
  - advances ix (wrapping to 0 at X_SIZE-1 and incrementing iy).
- If eng_idle[issue_ptr] = 0, the issue side stalls. It never skips to another engine, which keeps results in order.
- When pixel (X_SIZE-1, Y_SIZE-1) is issued, the state goes RUN → DRAIN.
- Collect rule, in RUN and DRAIN:
  - out_stream_tvalid = eng_done[col_ptr] (combinational from the registered col_ptr);
  - tdata is formed from eng_result of the col_ptr engine;
  - tuser = (ox==0 && oy==0);
  - tlast = (ox==X_SIZE-1).
- On a handshake (tvalid && tready), in the same cycle:
  - eng_ack[col_ptr] = 1 (combinational);
  - col_ptr, ox and oy advance at the clock edge.
- Engines hold their results until acked, so tdata/tuser/tlast stay stable while tvalid is high and tready is low.
- DRAIN → IDLE when the handshake of pixel (X_SIZE-1, Y_SIZE-1) completes. frame_done pulses on the next cycle.
- An engine is never started twice before its ack, because eng_idle stays low until the result is consumed.
- An ack and a start to the same engine in one cycle cannot occur. eng_idle rises only after the ack edge.

## Timing
- Issue latency: eng_start is asserted 1 cycle after eng_idle[issue_ptr] and the RUN state are both observed.
- Issue throughput: one start per cycle while engines are idle.
- Collect latency: tvalid is combinational from eng_done. There is zero added latency. Throughput is one pixel per cycle.
- start received while busy is ignored.
- periph_reset asserted mid-frame:
  - all outputs return to their reset values immediately;
  - engines are expected to be reset by the same signal;
  - there are no partial-frame artefacts after release.
- eng_x and eng_y hold their last values between starts.

## Configuration
- FRAME_LOOP_EN defined: on DRAIN → IDLE the block re-enters RUN automatically with counters cleared, so frames stream continuously.
  - The first frame still requires start.
  - frame_done pulses for every frame.
- FRAME_LOOP_EN undefined: the block stays in IDLE after each frame until the next start.

## Test plan
- Basic frame:
  - Setup: X_SIZE=4, Y_SIZE=2, NUM_ENG=4; engines done 3 cycles after start, result = 4·y+x; tready=1.
  - Required: 8 beats with tdata low byte 0..7; tuser only on beat 0; tlast on beats 3 and 7; frame_done one cycle after beat 7; busy=0 afterwards.
- Random backpressure:
  - Setup: same as basic frame, tready from a PRBS.
  - Required: the same 8 values in order; tdata/tuser/tlast stable whenever tvalid && !tready; exactly one eng_ack per handshake.
- Skewed engines:
  - Setup: engine 1 latency 20 cycles, others 2.
  - Required: output order is still raster order; tvalid stays low while waiting for engine 1; no eng_start to engine 1 before its ack.
- Start while busy:
  - Stimulus: pulse start mid-frame.
  - Required: no counter reset; exactly 8 beats.
- Mid-frame reset:
  - Stimulus: assert periph_reset after beat 3, then start again.
  - Required: tvalid=0 and eng_start=0 during reset; the next frame begins with tuser on x=0, y=0 and data 0.
- FRAME_LOOP_EN build:
  - Stimulus: one start pulse.
  - Required: three consecutive frames of 8 beats; tuser every 8th beat; three frame_done pulses; busy continuously high.

Source files
------------

// File: rtl/fractal_job_scheduler.sv
// Raster-order dispatch of fractal pixel jobs to NUM_ENG engines, in-order result collection
// into an AXI4-Stream video stream. Define FRAME_LOOP_EN to stream frames back-to-back.
module fractal_job_scheduler #(
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480,
    parameter int NUM_ENG = 4
) (
    input  logic                   out_stream_aclk,
    input  logic                   periph_reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    input  logic [NUM_ENG-1:0]     eng_idle,
    output logic [NUM_ENG-1:0]     eng_start,
    output logic [10:0]            eng_x,
    output logic [10:0]            eng_y,
    input  logic [NUM_ENG-1:0]     eng_done,
    input  logic [8*NUM_ENG-1:0]   eng_result,
    output logic [NUM_ENG-1:0]     eng_ack,
    output logic [31:0]            out_stream_tdata,
    output logic [3:0]             out_stream_tkeep,
    output logic                   out_stream_tvalid,
    input  logic                   out_stream_tready,
    output logic                   out_stream_tuser,
    output logic                   out_stream_tlast
);
    localparam int          IW     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [10:0] X_LAST = 11'(X_SIZE - 1);
    localparam logic [10:0] Y_LAST = 11'(Y_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_reg;
    logic [IW-1:0]      issue_ptr_reg, col_ptr_reg;
    logic [10:0]        ix_reg, iy_reg, ox_reg, oy_reg;
    logic [10:0]        eng_x_reg, eng_y_reg;
    logic [NUM_ENG-1:0] eng_start_reg;
    logic               frame_done_reg;
    logic [7:0]         result_arr [NUM_ENG];
    logic               active, issue_ok, handshake, last_out;
    logic [7:0]         pix;

    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_result
        assign result_arr[gi] = eng_result[8*gi +: 8];
    end

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(NUM_ENG - 1)) ? '0 : p + 1'b1;
    endfunction

    assign active    = (state_reg != IDLE);
    // A start still in flight hides the engine until its idle flag has had a chance to drop.
    assign issue_ok  = (state_reg == RUN) && eng_idle[issue_ptr_reg] && !eng_start_reg[issue_ptr_reg];
    assign pix       = result_arr[col_ptr_reg];
    assign handshake = out_stream_tvalid && out_stream_tready;
    assign last_out  = (ox_reg == X_LAST) && (oy_reg == Y_LAST);

    assign busy              = active;
    assign frame_done        = frame_done_reg;
    assign eng_start         = eng_start_reg;
    assign eng_x             = eng_x_reg;
    assign eng_y             = eng_y_reg;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tvalid = active && eng_done[col_ptr_reg];
    assign out_stream_tdata  = out_stream_tvalid ? {8'h00, pix, pix, pix} : 32'h0;
    assign out_stream_tuser  = out_stream_tvalid && (ox_reg == 11'd0) && (oy_reg == 11'd0);
    assign out_stream_tlast  = out_stream_tvalid && (ox_reg == X_LAST);
    assign eng_ack           = handshake ? (NUM_ENG'(1) << col_ptr_reg) : '0;

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_reg      <= IDLE;
            issue_ptr_reg  <= '0;
            col_ptr_reg    <= '0;
            ix_reg         <= '0;
            iy_reg         <= '0;
            ox_reg         <= '0;
            oy_reg         <= '0;
            eng_x_reg      <= '0;
            eng_y_reg      <= '0;
            eng_start_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            eng_start_reg  <= '0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= RUN;
                        issue_ptr_reg <= '0;
                        col_ptr_reg   <= '0;
                        ix_reg        <= '0;
                        iy_reg        <= '0;
                        ox_reg        <= '0;
                        oy_reg        <= '0;
                    end
                end
                RUN: begin
                    if (issue_ok) begin
                        eng_start_reg <= NUM_ENG'(1) << issue_ptr_reg;
                        eng_x_reg     <= ix_reg;
                        eng_y_reg     <= iy_reg;
                        issue_ptr_reg <= ptr_inc(issue_ptr_reg);
                        if (ix_reg == X_LAST) begin
                            ix_reg <= '0;
                            iy_reg <= iy_reg + 11'd1;
                            if (iy_reg == Y_LAST)
                                state_reg <= DRAIN;
                        end else begin
                            ix_reg <= ix_reg + 11'd1;
                        end
                    end
                end
                default: ;
            endcase

            if (handshake) begin
                col_ptr_reg <= ptr_inc(col_ptr_reg);
                if (ox_reg == X_LAST) begin
                    ox_reg <= '0;
                    oy_reg <= oy_reg + 11'd1;
                end else begin
                    ox_reg <= ox_reg + 11'd1;
                end
                // Last pixel can only be collected after its issue moved us to DRAIN.
                if (last_out && state_reg == DRAIN) begin
                    frame_done_reg <= 1'b1;
`ifdef FRAME_LOOP_EN
                    state_reg     <= RUN;
                    issue_ptr_reg <= '0;
                    col_ptr_reg   <= '0;
                    ix_reg        <= '0;
                    iy_reg        <= '0;
                    ox_reg        <= '0;
                    oy_reg        <= '0;
`else
                    state_reg     <= IDLE;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_fractal_job_scheduler.sv
// Self-checking bench for fractal_job_scheduler: latency-programmable engine models, a
// raster-order pixel model checked every cycle, and literal checks on captured frames.
module tb_fractal_job_scheduler;
    localparam int X  = 4;
    localparam int Y  = 2;
    localparam int NE = 4;
    localparam int N  = X * Y;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            tready = 1'b1;
    logic            busy, frame_done;
    logic [NE-1:0]   eng_idle, eng_start, eng_done, eng_ack;
    logic [10:0]     eng_x, eng_y;
    logic [8*NE-1:0] eng_result;
    logic [31:0]     tdata;
    logic [3:0]      tkeep;
    logic            tvalid, tuser, tlast;

    always #5 clk = ~clk;

    fractal_job_scheduler #(.X_SIZE(X), .Y_SIZE(Y), .NUM_ENG(NE)) dut (
        .out_stream_aclk(clk), .periph_reset(rst), .start(start),
        .busy(busy), .frame_done(frame_done),
        .eng_idle(eng_idle), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_result(eng_result), .eng_ack(eng_ack),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tvalid(tvalid),
        .out_stream_tready(tready), .out_stream_tuser(tuser), .out_stream_tlast(tlast)
    );

    // Engine models: latch coordinates on start, raise done after lat cycles, clear on ack.
    int          lat [NE];
    logic        e_run [NE];
    logic        e_done_q [NE];
    int          e_cnt [NE];
    logic [10:0] e_x [NE];
    logic [10:0] e_y [NE];
    logic [7:0]  e_res [NE];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                e_run[i] <= 1'b0; e_done_q[i] <= 1'b0; e_cnt[i] <= 0;
                e_x[i] <= '0; e_y[i] <= '0; e_res[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (eng_ack[i]) e_done_q[i] <= 1'b0;
                if (eng_start[i]) begin
                    e_run[i] <= 1'b1; e_cnt[i] <= lat[i]; e_x[i] <= eng_x; e_y[i] <= eng_y;
                end else if (e_run[i]) begin
                    if (e_cnt[i] <= 1) begin
                        e_run[i]    <= 1'b0;
                        e_done_q[i] <= 1'b1;
                        e_res[i]    <= 8'((int'(e_y[i]) * X + int'(e_x[i])) & 255);
                    end else begin
                        e_cnt[i] <= e_cnt[i] - 1;
                    end
                end
            end
        end
    end

    always_comb begin
        eng_idle   = '0;
        eng_done   = '0;
        eng_result = '0;
        for (int i = 0; i < NE; i++) begin
            eng_idle[i]          = !e_run[i] && !e_done_q[i];
            eng_done[i]          = e_done_q[i];
            eng_result[8*i +: 8] = e_res[i];
        end
    end

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endfunction

    // Frame model: raster pixel index per beat, engine = index mod NE, value = y*X + x.
    bit         m_active = 1'b0;
    int         m_beat = 0;
    int         m_issued = 0;
    bit         exp_fd = 1'b0;
    int         fd_count = 0;
    int         hs_total = 0;
    logic [7:0] cap_data [N];
    logic [N-1:0] cap_user, cap_last;

    always @(negedge clk) begin
        bit         was_active, exp_tv, hs;
        int         eng, px, py;
        logic [7:0] v;
        if (rst) begin
            chk("rst_tvalid", tvalid, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_eng_ack", eng_ack, 0);
            chk("rst_tkeep", tkeep, 4'hF);
            m_active = 1'b0; m_beat = 0; m_issued = 0; exp_fd = 1'b0;
        end else begin
            was_active = m_active;
            chk("busy", busy, m_active);
            chk("frame_done", frame_done, exp_fd);
            chk("tkeep", tkeep, 4'hF);
            if (frame_done) fd_count++;
            if (eng_start != 0) begin
                eng = m_issued % NE;
                chk("start_engine", eng_start, 32'(1) << eng);
                chk("start_x", eng_x, m_issued % X);
                chk("start_y", eng_y, m_issued / X);
                chk("start_target_free", {e_run[eng], e_done_q[eng]}, 0);
                chk("start_in_frame", (m_active && m_issued < N) ? 1 : 0, 1);
                m_issued++;
            end
            eng    = m_beat % NE;
            exp_tv = m_active && (m_beat < N) && e_done_q[eng];
            chk("tvalid", tvalid, exp_tv);
            hs = exp_tv && tready;
            chk("eng_ack", eng_ack, hs ? (32'(1) << eng) : 0);
            if (exp_tv) begin
                px = m_beat % X;
                py = m_beat / X;
                v  = 8'((py * X + px) & 255);
                chk("tdata", tdata, {8'h00, v, v, v});
                chk("tuser", tuser, (px == 0 && py == 0) ? 1 : 0);
                chk("tlast", tlast, (px == X - 1) ? 1 : 0);
            end
            if (hs) begin
                $display("beat %0d x=%0d y=%0d tdata=%08h tuser=%0b tlast=%0b",
                         m_beat, m_beat % X, m_beat / X, tdata, tuser, tlast);
                cap_data[m_beat] = tdata[7:0];
                cap_user[m_beat] = tuser;
                cap_last[m_beat] = tlast;
                hs_total++;
                m_beat++;
            end
            exp_fd = hs && (m_beat == N);
            if (exp_fd) begin
                chk("issue_count", m_issued, N);
                m_beat = 0;
                m_issued = 0;
`ifndef FRAME_LOOP_EN
                m_active = 1'b0;
`endif
            end
            if (!was_active && start) m_active = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit random_ready, input bit mid_start);
        int fd0, hs0, cyc;
        fd0 = fd_count;
        hs0 = hs_total;
        cyc = 0;
        tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (fd_count == fd0 && cyc < 3000) begin
            tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start  = (mid_start && cyc == 5) ? 1'b1 : 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        tready = 1'b1;
        chk("frame_timeout", (fd_count == fd0 + 1) ? 1 : 0, 1);
        chk("beats_per_frame", hs_total - hs0, N);
        for (int k = 0; k < N; k++) chk("lit_data", cap_data[k], k);
        chk("lit_tuser", cap_user, 8'b0000_0001);
        chk("lit_tlast", cap_last, 8'b1000_1000);
        tick(); tick();
        chk("idle_after_frame", busy, 0);
    endtask

    initial begin
        int hs0, fd0, cyc;
        for (int i = 0; i < NE; i++) lat[i] = 3;
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
`ifndef FRAME_LOOP_EN
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        lat[0] = 2; lat[1] = 20; lat[2] = 2; lat[3] = 2;
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        for (int i = 0; i < NE; i++) lat[i] = 3;
        run_frame(1'b1, 1'b1);
        // Reset after the fourth beat, then a clean frame must follow.
        hs0 = hs_total;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (hs_total < hs0 + 4 && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("midreset_reach_beat4", (hs_total >= hs0 + 4) ? 1 : 0, 1);
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        run_frame(1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NE; i++) lat[i] = $urandom_range(1, 8);
            run_frame(1'b1, 1'(r & 1));
        end
`else
        hs0 = hs_total;
        fd0 = fd_count;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (fd_count < fd0 + 3 && cyc < 3000) begin
            tready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        tready = 1'b1;
        chk("loop_frames", fd_count - fd0, 3);
        chk("loop_beats", hs_total - hs0, 3 * N);
        chk("loop_busy", busy, 1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
